// File: rtl/dmem_stall_ctrl.sv
// Data-memory stall controller: latches one core load/store, drives a wait-stated
// SRAM access, and holds the pipeline stalled until the access completes.
module dmem_stall_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        req;
    logic        bad_req;

    assign req     = cpu_read | cpu_write;
    assign bad_req = (cpu_addr[1:0] != 2'b00) | (cpu_read & cpu_write);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cpu_addr[31:2];
                        wdata_d = cpu_wdata;
                        we_d    = cpu_write;
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Runs to completion even if the core drops its request.
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign stall     = req & (state_q != DONE);
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign err       = err_q;

endmodule
